// File: rtl/dmem_access_unit_pkg.sv
// -----------------------------------------------------------------------------
// dmem_access_unit_pkg
// Shared types for the memory-stage access unit: load/store funct3 encodings,
// the access FSM state enum, default widths and the alignment check used when
// the misalignment trap (DMEM_MISALIGN_TRAP_EN) is built in.
// -----------------------------------------------------------------------------
package dmem_access_unit_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int MBE_W_DEF = XLEN_DEF / 8;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    F3_SB = 3'b000,
    F3_SH = 3'b001,
    F3_SW = 3'b010
  } store_funct3_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

  // Unlisted funct3 codes behave as word accesses, so they need full alignment.
  function automatic logic is_misaligned(input logic       is_store,
                                         input logic [2:0] funct3,
                                         input logic [1:0] addr_lo);
    logic mis;
    mis = |addr_lo;
    if (is_store) begin
      case (store_funct3_t'(funct3))
        F3_SB:   mis = 1'b0;
        F3_SH:   mis = addr_lo[0];
        default: mis = |addr_lo;
      endcase
    end else begin
      case (load_funct3_t'(funct3))
        F3_LB, F3_LBU: mis = 1'b0;
        F3_LH, F3_LHU: mis = addr_lo[0];
        default:       mis = |addr_lo;
      endcase
    end
    return mis;
  endfunction

endpackage

// File: rtl/dmem_access_unit_load_extend.sv
// -----------------------------------------------------------------------------
// dmem_access_unit_load_extend
// Combinational lane select and sign/zero extension of a memory read word.
// Ports:
//   funct3    in  3     load funct3 (unlisted codes return the whole word)
//   addr_lo   in  2     byte offset within the word
//   rdata     in  XLEN  raw memory word
//   load_data out XLEN  extended load result
// -----------------------------------------------------------------------------
module dmem_access_unit_load_extend
  import dmem_access_unit_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    load_data = rdata;
    case (load_funct3_t'(funct3))
      F3_LB:   load_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  load_data = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH:   load_data = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LHU:  load_data = {{(XLEN-16){1'b0}}, half_sel};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/dmem_access_unit.sv
// -----------------------------------------------------------------------------
// dmem_access_unit
// Memory-stage responder: accepts one load/store per instruction, drives the
// word-addressed data-memory port until dmem_resp, stalls the pipeline while
// the access is outstanding and returns extended load data.
//
// Build option: DMEM_MISALIGN_TRAP_EN -- misaligned half/word accesses are not
// issued; the unit goes straight to DONE and pulses misalign_err. Without it,
// low address bits are ignored and misalign_err is tied low.
//
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   req_valid/read/write/funct3    MEM-stage control word
//   req_addr, req_wdata            effective address, store source (rs2)
//   dmem_resp, dmem_rdata          memory completion and read word
//   dmem_read, dmem_write          memory strobes (BUSY only)
//   dmem_address/mbe/wdata         word address, byte enables, lane data
//   stall                          hold upstream pipeline registers
//   load_valid, load_data          one-cycle load completion, held result
//   misalign_err                   misaligned access flag (DONE cycle)
//
// state | meaning
// IDLE  | waiting for a request; accepts and stalls in the same cycle
// BUSY  | strobes driven from registers until dmem_resp
// DONE  | pipeline advances, load_valid/misalign_err reported, req ignored
// -----------------------------------------------------------------------------
module dmem_access_unit
  import dmem_access_unit_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int MBE_W = MBE_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic             req_read,
  input  logic             req_write,
  input  logic [2:0]       req_funct3,
  input  logic [XLEN-1:0]  req_addr,
  input  logic [XLEN-1:0]  req_wdata,
  input  logic             dmem_resp,
  input  logic [XLEN-1:0]  dmem_rdata,
  output logic             dmem_read,
  output logic             dmem_write,
  output logic [XLEN-1:0]  dmem_address,
  output logic [MBE_W-1:0] dmem_mbe,
  output logic [XLEN-1:0]  dmem_wdata,
  output logic             stall,
  output logic             load_valid,
  output logic [XLEN-1:0]  load_data,
  output logic             misalign_err
);

  dmem_state_t      state_q, state_d;
  logic             request;
  logic             accept;
  logic             misalign;
  logic [MBE_W-1:0] mbe_d, mbe_q;
  logic [XLEN-1:0]  wdata_d, wdata_q;
  logic [XLEN-1:0]  addr_q;
  logic [1:0]       addr_lo_q;
  logic [2:0]       funct3_q;
  logic             store_q;
  logic             misalign_q;
  logic [XLEN-1:0]  ext_data;
  logic [XLEN-1:0]  load_data_q;

  // read and write together is a store: req_write alone decides the type.
  assign request = req_valid & (req_read | req_write);
  assign accept  = (state_q == IDLE) & request;

`ifdef DMEM_MISALIGN_TRAP_EN
  assign misalign = is_misaligned(req_write, req_funct3, req_addr[1:0]);
`else
  assign misalign = 1'b0;
`endif

  // Lane data is replicated so the memory can pick any lane by byte enable.
  always_comb begin
    mbe_d   = '1;
    wdata_d = '0;
    if (req_write) begin
      case (store_funct3_t'(req_funct3))
        F3_SB: begin
          mbe_d   = MBE_W'(1) << req_addr[1:0];
          wdata_d = {(XLEN/8){req_wdata[7:0]}};
        end
        F3_SH: begin
          mbe_d   = MBE_W'(3) << {req_addr[1], 1'b0};
          wdata_d = {(XLEN/16){req_wdata[15:0]}};
        end
        default: begin
          mbe_d   = '1;
          wdata_d = req_wdata;
        end
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    case (state_q)
      IDLE: begin
        if (request) begin
          stall   = 1'b1;
          state_d = misalign ? DONE : BUSY;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (dmem_resp) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  dmem_access_unit_load_extend #(.XLEN(XLEN)) u_load_extend (
    .funct3    (funct3_q),
    .addr_lo   (addr_lo_q),
    .rdata     (dmem_rdata),
    .load_data (ext_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      addr_lo_q   <= '0;
      funct3_q    <= '0;
      store_q     <= 1'b0;
      misalign_q  <= 1'b0;
      mbe_q       <= '0;
      wdata_q     <= '0;
      load_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q     <= {req_addr[XLEN-1:2], 2'b00};
        addr_lo_q  <= req_addr[1:0];
        funct3_q   <= req_funct3;
        store_q    <= req_write;
        misalign_q <= misalign;
        mbe_q      <= mbe_d;
        wdata_q    <= wdata_d;
      end
      if ((state_q == BUSY) && dmem_resp && !store_q) begin
        load_data_q <= ext_data;
      end
    end
  end

  // Strobes decode from the state register so an async reset drops them at once.
  assign dmem_read    = (state_q == BUSY) & ~store_q;
  assign dmem_write   = (state_q == BUSY) &  store_q;
  assign dmem_address = addr_q;
  assign dmem_mbe     = mbe_q;
  assign dmem_wdata   = wdata_q;
  assign load_valid   = (state_q == DONE) & ~store_q & ~misalign_q;
  assign misalign_err = (state_q == DONE) &  misalign_q;
  assign load_data    = load_data_q;

endmodule

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
Memory-stage responder for the per-instruction control word's mem_read/mem_write requests. It accepts one load/store per instruction from the EX/MEM boundary, drives the word-addressed data-memory port until dmem_resp, and stalls the pipeline meanwhile. It also generates store byte-enables and replicated write data, and returns aligned, sign/zero-extended load data for the regfile load path.

Parameters:
XLEN, 32, datapath/address width
MBE_W, 4, byte-enable width (XLEN/8)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  instruction in MEM stage is valid
req_read  in  1  control word mem_read
req_write  in  1  control word mem_write
req_funct3  in  3  load/store funct3 from control word
req_addr  in  XLEN  effective address (ALU output)
req_wdata  in  XLEN  rs2 value for stores
dmem_resp  in  1  memory completes current access
dmem_rdata  in  XLEN  memory read word
dmem_read  out  1  read strobe
dmem_write  out  1  write strobe
dmem_address  out  XLEN  word-aligned address {addr[31:2],2'b00}
dmem_mbe  out  MBE_W  byte enables
dmem_wdata  out  XLEN  lane-replicated store data
stall  out  1  hold all upstream pipeline registers
load_valid  out  1  one-cycle strobe: load_data valid
load_data  out  XLEN  extended load result
misalign_err  out  1  see Optional Feature (0 when macro absent)

Behaviour:
- Reset (async, rst_n=0): state IDLE; dmem_read/dmem_write/load_valid/misalign_err=0; dmem_address/mbe/wdata/load_data=0. Reset mid-access abandons transaction; strobes drop immediately.
- States: IDLE, BUSY, DONE.
- IDLE: request = req_valid & (req_read|req_write). If request: register addr/funct3/wdata/type, stall=1 (combinational), next BUSY. Otherwise stall=0.
- read&write both set: treated as store.
- BUSY: strobes and memory outputs driven from registers, stable until dmem_resp; stall=1. On dmem_resp: capture extended rdata (loads), next DONE; stall stays 1 this cycle.
- DONE: stall=0, load_valid=1 for loads (0 for stores), strobes 0; pipeline advances at end of cycle; req inputs ignored (same instruction); next IDLE.
- Minimum latency: 3 cycles (accept, one BUSY with immediate resp, DONE). A back-to-back access is accepted in the IDLE cycle following DONE.
- dmem_resp outside BUSY: ignored.
- Store lanes: SB mbe=4'b0001<<addr[1:0], wdata={4{b}}; SH mbe=4'b0011<<{addr[1],0}, wdata={2{h}}; SW mbe=4'b1111, wdata=rs2. Other store funct3: SW.
- Loads: dmem_mbe=4'b1111. LB/LBU select byte addr[1:0]; LH/LHU select half addr[1]; sign- or zero-extend to XLEN; LW whole word. funct3 3/6/7: LW.
- load_data holds its value until the next load completes.

Optional Feature:
DMEM_MISALIGN_TRAP_EN. Defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, is not issued. IDLE moves straight to DONE with misalign_err=1 and load_valid=0 for that one cycle; stall is asserted only in the accept cycle; memory strobes never assert. Undefined: low address bits are silently ignored as described above, and misalign_err is tied 0.

Decomposition:
- rv32i_types package: reuse load_funct3_t/store_funct3_t; add dmem_state_t enum {IDLE,BUSY,DONE}.
- One combinational sub-module, load_extend: takes funct3, addr[1:0], rdata; returns load_data.

Test Plan:
- SW addr 0x100 data 0xDEADBEEF, resp after 2 BUSY cycles -> dmem_write=1 address 0x100 mbe 1111 wdata 0xDEADBEEF, held 2 cycles; stall high 3 cycles, low in DONE.
- SB addr 0x103 data 0x000000A5 -> mbe 1000, wdata 0xA5A5A5A5. SH addr 0x102 data 0x1234 -> mbe 1100, wdata 0x12341234.
- LB addr 0x201 with rdata 0x0000_80FF -> load_data 0xFFFFFF80. LBU -> 0x00000080. LH addr 0x202 with rdata 0x8001_0000 -> 0xFFFF8001.
- Back-to-back LW then SW, each with immediate resp -> 3 cycles each, no gap beyond DONE→IDLE, no duplicate issue in the DONE cycle.
- rst_n low in BUSY -> strobes/stall 0 asynchronously; after release, IDLE accepts a new request normally.
- With macro: LW addr 0x102 -> no strobe, misalign_err=1 one cycle. Without macro: same access issues address 0x100, mbe 1111.
